pqvalue_ntt_ctrl: RTL and testbench

PQVALUE_NTT_CTRL -- requirements
Module: pqvalue_ntt_ctrl

---
 rtl/pqvalue_pkg.sv | 24 ++
 rtl/pqvalue_ntt_addr_gen.sv | 36 +++
 rtl/pqvalue_ntt_ctrl.sv | 116 +++++++++++
 tb/tb_pqvalue_ntt_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pqvalue_pkg.sv
// Shared constants and types for the PQ NTT controller slice.
package pqvalue_pkg;

    localparam int PQ_N     = 256;
    localparam int PQ_AW    = 8;
    localparam int PQ_LW    = 3;
    localparam int PQ_L_DIL = 8;
    localparam int PQ_L_KYB = 7;
    localparam int PQ_Q_DIL = 8380417;
    localparam int PQ_Q_KYB = 3329;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } ntt_state_t;

    // mode_red: 0 Dilithium, 1 Kyber
    function automatic int num_layers(input logic mode_red);
        return mode_red ? PQ_L_KYB : PQ_L_DIL;
    endfunction

endpackage

// File: rtl/pqvalue_ntt_addr_gen.sv
// Butterfly pair and twiddle index for butterfly idx of a layer; purely combinational.
module pqvalue_ntt_addr_gen
    import pqvalue_pkg::*;
#(
    parameter int AW = PQ_AW
) (
    input  logic [AW-2:0]    idx,
    input  logic [PQ_LW-1:0] layer,
    input  logic             mode_red,
    input  logic             mode_inv,
    output logic [AW-1:0]    addr_a,
    output logic [AW-1:0]    addr_b,
    output logic [AW-1:0]    k
);

    int            lg;
    logic [AW-1:0] i_ext, len, off, grp;

    // Group base is idx with the offset bits cleared, times two; no divider needed.
    // Inverse twiddles run down from 2^L-1; 2^L may overflow AW bits, the
    // modulo-2^AW subtraction still lands on the right index.
    always_comb begin
        i_ext  = {1'b0, idx};
        lg     = mode_inv ? int'(layer) + int'(mode_red) : AW - 1 - int'(layer);
        len    = AW'(1) << lg;
        off    = i_ext & (len - AW'(1));
        grp    = i_ext >> lg;
        addr_a = ((i_ext - off) << 1) | off;
        addr_b = addr_a + len;
        if (mode_inv)
            k = (AW'(1) << (num_layers(mode_red) - int'(layer))) - AW'(1) - grp;
        else
            k = (AW'(1) << layer) + grp;
    end

endmodule

// File: rtl/pqvalue_ntt_ctrl.sv
// NTT/INTT sequencing controller: one butterfly per cycle, one drain cycle per layer,
// write-back addresses trail the read addresses by the one-cycle RAM latency.
module pqvalue_ntt_ctrl
    import pqvalue_pkg::*;
#(
    parameter int N  = PQ_N,
    parameter int AW = PQ_AW
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic          mode_red_i,
    input  logic          mode_inv_i,
    output logic          rd_en_o,
    output logic [AW-1:0] rd_addr_a_o,
    output logic [AW-1:0] rd_addr_b_o,
    output logic          tw_en_o,
    output logic [AW-1:0] tw_addr_o,
    output logic          wr_en_o,
    output logic [AW-1:0] wr_addr_a_o,
    output logic [AW-1:0] wr_addr_b_o,
    output logic          sel_red_o,
    output logic          sel_butterfly_o,
    output logic          busy_o,
    output logic          done_o
);

    localparam logic [AW-2:0] IDX_LAST = (AW-1)'(N/2 - 1);

    ntt_state_t       state;
    logic [AW-2:0]    idx;
    logic [PQ_LW-1:0] layer;
    logic             mode_red_q, mode_inv_q;
    logic             run, last_layer;
    logic [AW-1:0]    addr_a, addr_b, k;

    assign run        = (state == S_RUN);
    assign last_layer = (int'(layer) == num_layers(mode_red_q) - 1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= S_IDLE;
            idx        <= '0;
            layer      <= '0;
            mode_red_q <= 1'b0;
            mode_inv_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start_i) begin
                    state      <= S_RUN;
                    idx        <= '0;
                    layer      <= '0;
                    mode_red_q <= mode_red_i;
                    mode_inv_q <= mode_inv_i;
                end
                S_RUN: begin
                    if (idx == IDX_LAST) begin
                        idx   <= '0;
                        state <= S_DRAIN;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                // Lets the last write-back of the layer land before the next layer reads.
                S_DRAIN: begin
                    if (last_layer) begin
                        state <= S_DONE;
                    end else begin
                        layer <= layer + 1'b1;
                        state <= S_RUN;
                    end
                end
                S_DONE: begin
                    state      <= S_IDLE;
                    layer      <= '0;
                    mode_red_q <= 1'b0;
                    mode_inv_q <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    pqvalue_ntt_addr_gen #(.AW(AW)) u_addr_gen (
        .idx      (idx),
        .layer    (layer),
        .mode_red (mode_red_q),
        .mode_inv (mode_inv_q),
        .addr_a   (addr_a),
        .addr_b   (addr_b),
        .k        (k)
    );

    assign rd_en_o         = run;
    assign tw_en_o         = run;
    assign rd_addr_a_o     = run ? addr_a : '0;
    assign rd_addr_b_o     = run ? addr_b : '0;
    assign tw_addr_o       = run ? k : '0;
    assign sel_red_o       = mode_red_q;
    assign sel_butterfly_o = mode_inv_q;
    assign busy_o          = (state != S_IDLE);
    assign done_o          = (state == S_DONE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_en_o     <= 1'b0;
            wr_addr_a_o <= '0;
            wr_addr_b_o <= '0;
        end else begin
            wr_en_o     <= rd_en_o;
            wr_addr_a_o <= rd_addr_a_o;
            wr_addr_b_o <= rd_addr_b_o;
        end
    end

endmodule

// File: tb/tb_pqvalue_ntt_ctrl.sv
// Self-checking bench for pqvalue_ntt_ctrl: table-driven transforms against a trace model.
module tb_pqvalue_ntt_ctrl;

    localparam int N  = 256;
    localparam int AW = 8;

    logic          clk_i = 1'b0;
    logic          rst_ni, start_i, mode_red_i, mode_inv_i;
    logic          rd_en_o, tw_en_o, wr_en_o;
    logic [AW-1:0] rd_addr_a_o, rd_addr_b_o, tw_addr_o, wr_addr_a_o, wr_addr_b_o;
    logic          sel_red_o, sel_butterfly_o, busy_o, done_o;

    int checks = 0;
    int errors = 0;

    pqvalue_ntt_ctrl #(.N(N), .AW(AW)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .start_i         (start_i),
        .mode_red_i      (mode_red_i),
        .mode_inv_i      (mode_inv_i),
        .rd_en_o         (rd_en_o),
        .rd_addr_a_o     (rd_addr_a_o),
        .rd_addr_b_o     (rd_addr_b_o),
        .tw_en_o         (tw_en_o),
        .tw_addr_o       (tw_addr_o),
        .wr_en_o         (wr_en_o),
        .wr_addr_a_o     (wr_addr_a_o),
        .wr_addr_b_o     (wr_addr_b_o),
        .sel_red_o       (sel_red_o),
        .sel_butterfly_o (sel_butterfly_o),
        .busy_o          (busy_o),
        .done_o          (done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit red, inv, tbl;
        int done_cyc;
        int a1, b1, k1;
        int pc, pa, pb, pk;
    } vec_t;

    typedef struct {
        bit rd;
        int a, b, k;
        bit busy, done;
    } exp_t;

    task automatic chk(input string name, input int cyc, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({rd_en_o, rd_addr_a_o, rd_addr_b_o, tw_en_o, tw_addr_o, wr_en_o,
                    wr_addr_a_o, wr_addr_b_o, sel_red_o, sel_butterfly_o, busy_o, done_o});
    endfunction

    // Trace model: one entry per cycle from the start edge, built from the layer/twiddle rules.
    task automatic build_trace(input bit red, input bit inv, output exp_t tr[$]);
        int   nl, len, k;
        bit   first;
        exp_t e;
        tr    = {};
        nl    = red ? 7 : 8;
        len   = inv ? (N >> nl) : N / 2;
        k     = inv ? (1 << nl) - 1 : 1;
        first = 1;
        e = '{rd: 0, a: 0, b: 0, k: 0, busy: 0, done: 0};
        tr.push_back(e);
        for (int l = 0; l < nl; l++) begin
            for (int i = 0; i < N / 2; i++) begin
                if (i % len == 0) begin
                    if (!first) k = inv ? k - 1 : k + 1;
                    first = 0;
                end
                e = '{rd: 1, a: 2 * len * (i / len) + i % len, b: 2 * len * (i / len) + i % len + len,
                      k: k, busy: 1, done: 0};
                tr.push_back(e);
            end
            e = '{rd: 0, a: 0, b: 0, k: 0, busy: 1, done: 0};
            tr.push_back(e);
            len = inv ? len * 2 : len / 2;
        end
        e = '{rd: 0, a: 0, b: 0, k: 0, busy: 1, done: 1};
        tr.push_back(e);
        e = '{rd: 0, a: 0, b: 0, k: 0, busy: 0, done: 0};
        tr.push_back(e);
        tr.push_back(e);
    endtask

    task automatic do_reset(input int cyc);
        rst_ni = 1'b0;
        #1;
        chk("reset_async_outputs", cyc, all_outs(), 64'd0);
        @(negedge clk_i);
        chk("reset_held_outputs", cyc + 1, all_outs(), 64'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("idle_after_reset", cyc + 2, all_outs(), 64'd0);
    endtask

    task automatic run_xform(input vec_t v, input int poke, input int rst_at);
        exp_t tr[$];
        int   done_seen;
        done_seen = -1;
        build_trace(v.red, v.inv, tr);
        @(negedge clk_i);
        start_i    = 1'b1;
        mode_red_i = v.red;
        mode_inv_i = v.inv;
        @(negedge clk_i);
        start_i    = 1'b0;
        mode_red_i = 1'($urandom);
        mode_inv_i = 1'($urandom);
        for (int c = 1; c < tr.size(); c++) begin
            if (c == rst_at) begin
                do_reset(c);
                return;
            end
            chk("ctrl_flags", c, 64'({rd_en_o, tw_en_o, busy_o, done_o}),
                64'({tr[c].rd, tr[c].rd, tr[c].busy, tr[c].done}));
            if (tr[c].rd)
                chk("rd_tw_addr", c, 64'({rd_addr_a_o, rd_addr_b_o, tw_addr_o}),
                    64'({AW'(tr[c].a), AW'(tr[c].b), AW'(tr[c].k)}));
            chk("wr_en_delay", c, 64'(wr_en_o), 64'(tr[c-1].rd));
            if (tr[c-1].rd)
                chk("wr_addr_delay", c, 64'({wr_addr_a_o, wr_addr_b_o}),
                    64'({AW'(tr[c-1].a), AW'(tr[c-1].b)}));
            if (tr[c].busy)
                chk("sel_held", c, 64'({sel_red_o, sel_butterfly_o}), 64'({v.red, v.inv}));
            if (v.tbl && c == 1)
                chk("first_pair", c, 64'({rd_addr_a_o, rd_addr_b_o, tw_addr_o}),
                    64'({AW'(v.a1), AW'(v.b1), AW'(v.k1)}));
            if (v.tbl && c == v.pc)
                chk("probe_pair", c, 64'({rd_addr_a_o, rd_addr_b_o, tw_addr_o}),
                    64'({AW'(v.pa), AW'(v.pb), AW'(v.pk)}));
            if (done_o === 1'b1 && done_seen < 0) done_seen = c;
            start_i = (c == poke);
            @(negedge clk_i);
        end
        start_i = 1'b0;
        if (v.tbl) chk("done_cycle", 0, 64'(done_seen), 64'(v.done_cyc));
    endtask

    initial begin
        vec_t tbl[4];
        vec_t rv;
        tbl[0] = '{red: 0, inv: 0, tbl: 1, done_cyc: 1033, a1: 0, b1: 128, k1: 1,   pc: 194, pa: 128, pb: 192, pk: 3};
        tbl[1] = '{red: 1, inv: 0, tbl: 1, done_cyc: 904,  a1: 0, b1: 128, k1: 1,   pc: 130, pa: 0,   pb: 64,  pk: 2};
        tbl[2] = '{red: 1, inv: 1, tbl: 1, done_cyc: 904,  a1: 0, b1: 2,   k1: 127, pc: 3,   pa: 4,   pb: 6,   pk: 126};
        tbl[3] = '{red: 0, inv: 1, tbl: 1, done_cyc: 1033, a1: 0, b1: 1,   k1: 255, pc: 904, pa: 0,   pb: 128, pk: 1};

        rst_ni     = 1'b0;
        start_i    = 1'b0;
        mode_red_i = 1'b0;
        mode_inv_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("reset_state", 0, all_outs(), 64'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("idle_no_start", 0, all_outs(), 64'd0);

        foreach (tbl[t]) run_xform(tbl[t], -1, -1);

        // start pulses while busy (mid-run and in the DONE cycle) must be ignored
        run_xform(tbl[0], 500, -1);
        run_xform(tbl[1], 904, -1);
        run_xform(tbl[2], 129, -1);

        // reset mid-transform, then a full-length run
        run_xform(tbl[0], -1, 300);
        run_xform(tbl[0], -1, -1);

        for (int r = 0; r < 3; r++) begin
            rv     = tbl[0];
            rv.tbl = 0;
            rv.red = 1'($urandom);
            rv.inv = 1'($urandom);
            run_xform(rv, int'($urandom_range(1, 1100)), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
